exec: RTL and testbench

- Execute-stage integer ALU for the RVP pipeline.
- Takes two 32-bit operands and a 4-bit operation code, and produces one registered 32-bit result one clock later.
- Purely arithmetic/logic: no memory access, no branch resolution, no pipeline stall logic.

---
 rtl/exec_pkg.sv | 17 +
 rtl/exec_alu_comb.sv | 34 +++
 rtl/exec.sv | 45 ++++
 tb/tb_exec.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared constants and operation codes for the RVP execute-stage ALU
package exec_pkg;

    localparam int XLEN    = 32;
    localparam int SHAMT_W = 5;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;
    localparam logic [3:0] OP_SLT = 4'd8;

endpackage

// File: rtl/exec_alu_comb.sv
// rtl/exec_alu_comb.sv - combinational result mux of the execute-stage ALU
module exec_alu_comb #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    input  logic [3:0]      operation,
    output logic [XLEN-1:0] result
);
    import exec_pkg::*;

    logic [SHAMT_W-1:0] shamt;

    assign shamt = operand2[SHAMT_W-1:0];

    // Reserved and unknown codes fall into default and produce zero.
    always_comb begin
        result = '0;
        case (operation)
            OP_ADD:  result = operand1 + operand2;
            OP_SUB:  result = operand1 - operand2;
            OP_AND:  result = operand1 & operand2;
            OP_OR:   result = operand1 | operand2;
            OP_XOR:  result = operand1 ^ operand2;
            OP_SLL:  result = operand1 << shamt;
            OP_SRL:  result = operand1 >> shamt;
            OP_SRA:  result = $signed(operand1) >>> shamt;
            OP_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(operand1) < $signed(operand2))};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/exec.sv
// rtl/exec.sv - execute-stage ALU top: one-cycle registered result with valid and zero flags
module exec #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] Operand1,
    input  logic [XLEN-1:0] Operand2,
    input  logic [3:0]      Operation,
    input  logic            in_valid,
    output logic [XLEN-1:0] Out,
    output logic            out_valid,
    output logic            zero
);
    import exec_pkg::*;

    logic [XLEN-1:0] result;

    exec_alu_comb #(
        .XLEN    (XLEN),
        .SHAMT_W (SHAMT_W)
    ) u_alu (
        .operand1  (Operand1),
        .operand2  (Operand2),
        .operation (Operation),
        .result    (result)
    );

    // Out and zero only move on accepted inputs; idle cycles hold the last result.
    always_ff @(posedge clk) begin
        if (rst) begin
            Out       <= '0;
            zero      <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                Out  <= result;
                zero <= (result == '0);
            end
        end
    end

endmodule

// File: tb/tb_exec.sv
// tb/tb_exec.sv - scoreboard testbench for the execute-stage ALU
module tb_exec;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Operand1;
    logic [31:0] Operand2;
    logic [3:0]  Operation;
    logic        in_valid;
    logic [31:0] Out;
    logic        out_valid;
    logic        zero;

    int checks = 0;
    int errors = 0;

    string       q_name[$];
    logic        q_valid[$];
    logic [31:0] q_out[$];
    logic        q_zero[$];

    logic [31:0] m_out  = 32'd0;
    logic        m_zero = 1'b1;
    bit          stim_done = 1'b0;

    exec dut (
        .clk       (clk),
        .rst       (rst),
        .Operand1  (Operand1),
        .Operand2  (Operand2),
        .Operation (Operation),
        .in_valid  (in_valid),
        .Out       (Out),
        .out_valid (out_valid),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (op)
            0: r = a + b;
            1: r = a - b;
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = a << b[4:0];
            6: r = a >> b[4:0];
            7: r = $signed(a) >>> b[4:0];
            8: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Drive one cycle and push what the outputs must show after the next edge.
    task automatic step(input bit r, input bit v, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string name);
        logic ev;
        rst = r; in_valid = v; Operation = op; Operand1 = a; Operand2 = b;
        if (r) begin
            m_out = 32'd0; m_zero = 1'b1; ev = 1'b0;
        end else if (v) begin
            m_out = exp; m_zero = (exp == 32'd0); ev = 1'b1;
        end else begin
            ev = 1'b0;
        end
        q_name.push_back(name);
        q_valid.push_back(ev);
        q_out.push_back(m_out);
        q_zero.push_back(m_zero);
        @(posedge clk);
        #1;
    endtask

    // Monitor: each cycle's outputs are compared against the oldest expectation.
    initial begin
        string       n;
        logic        ev;
        logic [31:0] eo;
        logic        ez;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (q_name.size() > 0) begin
                n = q_name.pop_front(); ev = q_valid.pop_front();
                eo = q_out.pop_front(); ez = q_zero.pop_front();
                checks++;
                if (out_valid !== ev) begin
                    errors++;
                    $display("FAIL %s out_valid got %b want %b", n, out_valid, ev);
                end
                checks++;
                if (Out !== eo) begin
                    errors++;
                    $display("FAIL %s Out got %h want %h", n, Out, eo);
                end
                checks++;
                if (zero !== ez) begin
                    errors++;
                    $display("FAIL %s zero got %b want %b", n, zero, ez);
                end
            end
        end
    end

    initial begin
        int          op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  xop;

        step(1, 1, 4'd0, $urandom, $urandom, 32'd0, "reset0");
        step(1, 1, 4'd3, $urandom, $urandom, 32'd0, "reset1");
        step(0, 0, 4'd0, 32'd5, 32'd6, 32'd0, "post_reset_idle");

        step(0, 1, 4'd0, 32'd23, 32'd202, 32'd225,        "add");
        step(0, 1, 4'd1, 32'd23, 32'd202, 32'hFFFFFF4D,   "sub");
        step(0, 1, 4'd2, 32'd23, 32'd202, 32'd2,          "and");
        step(0, 1, 4'd3, 32'd23, 32'd202, 32'd223,        "or");
        step(0, 1, 4'd4, 32'd23, 32'd202, 32'd221,        "xor");
        step(0, 1, 4'd5, 32'd23, 32'd202, 32'd23552,      "sll");
        step(0, 1, 4'd6, 32'd23, 32'd202, 32'd0,          "srl");
        step(0, 1, 4'd7, 32'd23, 32'd202, 32'd0,          "sra");
        step(0, 1, 4'd8, 32'd23, 32'd202, 32'd1,          "slt");

        step(0, 1, 4'd7, 32'h80000000, 32'd31, 32'hFFFFFFFF, "sra_edge");
        step(0, 1, 4'd6, 32'h80000000, 32'd31, 32'd1,        "srl_edge");
        step(0, 1, 4'd5, 32'd1, 32'hFFFFFFE4, 32'h10,        "sll_high_ignored");
        step(0, 1, 4'd8, 32'hFFFFFFFF, 32'd1, 32'd1,         "slt_signed");
        step(0, 1, 4'd8, 32'd1, 32'hFFFFFFFF, 32'd0,         "slt_signed_neg");
        step(0, 1, 4'd0, 32'hFFFFFFFF, 32'd1, 32'd0,         "add_wrap");

        step(0, 1, 4'd3, 32'd7, 32'd8, 32'd15,               "pre_reserved");
        step(0, 1, 4'd9, 32'd7, 32'd8, 32'd0,                "reserved9");
        step(0, 1, 4'd4, 32'd7, 32'd8, 32'd15,               "pre_reserved15");
        step(0, 1, 4'd15, 32'hDEAD, 32'hBEEF, 32'd0,         "reserved15");
        step(0, 1, 4'd0, 32'd1, 32'd2, 32'd3,                "pre_unknown");
        xop = 4'bxxxx;
        step(0, 1, xop, 32'd0, 32'd0, 32'd0,                 "unknown_op");

        step(0, 1, 4'd0, 32'd100, 32'd23, 32'd123,           "gate_v1");
        step(0, 0, 4'd1, 32'd999, 32'd1, 32'd0,              "gate_idle1");
        step(0, 0, 4'd2, 32'd0, 32'd0, 32'd0,                "gate_idle2");
        step(0, 1, 4'd4, 32'hF0F0, 32'h0FF0, 32'hFF00,       "gate_v2");

        step(0, 1, 4'd0, 32'd10, 32'd20, 32'd30,             "mid_stream");
        step(1, 1, 4'd0, 32'd10, 32'd20, 32'd0,              "mid_reset");
        step(0, 1, 4'd1, 32'd50, 32'd8, 32'd42,              "after_reset");

        for (int i = 0; i < 20; i++) begin
            op = $urandom_range(8);
            a  = $urandom;
            b  = $urandom;
            step(0, 1, 4'(op), a, b, ref_alu(op, a, b), "soak");
        end
        step(0, 0, 4'd0, 32'd0, 32'd0, 32'd0, "tail_idle");
        in_valid = 1'b0;

        for (int i = 0; i < 10 && q_name.size() > 0; i++) @(posedge clk);
        #1;
        @(negedge clk);
        #1;
        if (q_name.size() > 0) begin
            errors++;
            $display("FAIL drain pending %0d want 0", q_name.size());
        end
        stim_done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        if (!stim_done) begin
            $display("FAIL timeout reached want finish");
            $fatal(1);
        end
    end

endmodule
